// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract datapath.
// Stage payload: per-beat control bits; operand/sum slices travel beside it as WIDTH-bit vectors.
package adder_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_ctrl_t;

    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage: CHUNK-bit ripple adder plus payload register with a shared hold enable.
// The final stage also registers the overflow and zero flags of the completed sum.
module adder_stage
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter bit          FINAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  stage_ctrl_t      ctrl_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    output stage_ctrl_t      ctrl_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             ovf,
    output logic             zero
);

    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] sum_next;
    logic [CHUNK-1:0] sum_dropped_unused;

    // New chunk enters at the top of the sum; earlier chunks slide down, landing in place after the last stage.
    always_comb begin
        part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + (CHUNK+1)'(ctrl_in.carry);
        {sum_next, sum_dropped_unused} = {part[CHUNK-1:0], sum_in};
    end

    // Data fields only load for real beats, so outputs keep their last value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_out <= '0;
            a_out    <= '0;
            b_out    <= '0;
            sum_out  <= '0;
        end else if (en) begin
            ctrl_out.valid <= ctrl_in.valid;
            if (ctrl_in.valid) begin
                ctrl_out.carry <= part[CHUNK];
                ctrl_out.a_msb <= ctrl_in.a_msb;
                ctrl_out.b_msb <= ctrl_in.b_msb;
                a_out          <= a_in >> CHUNK;
                b_out          <= b_in >> CHUNK;
                sum_out        <= sum_next;
            end
        end
    end

    generate
        if (FINAL) begin : g_flags
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf  <= 1'b0;
                    zero <= 1'b0;
                end else if (en && ctrl_in.valid) begin
                    ovf  <= (ctrl_in.a_msb == ctrl_in.b_msb) && (sum_next[WIDTH-1] != ctrl_in.a_msb);
                    zero <= (sum_next == '0);
                end
            end
        end else begin : g_no_flags
            assign ovf  = 1'b0;
            assign zero = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract with the carry chain split over STAGES registers and
// valid/ready handshakes on both sides; whole pipeline advances or holds as one.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_adder: WIDTH=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= WIDTH",
                   WIDTH, STAGES);
        end
    endgenerate

    stage_ctrl_t      entry_ctrl;
    logic [WIDTH-1:0] entry_b;
    logic             advance;

    stage_ctrl_t       ctrl_s [STAGES];
    logic [WIDTH-1:0]  a_s    [STAGES];
    logic [WIDTH-1:0]  b_s    [STAGES];
    logic [WIDTH-1:0]  sum_s  [STAGES];
    logic [STAGES-1:0] ovf_s;
    logic [STAGES-1:0] zero_s;
    logic              tail_unused;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as the stage-0 carry.
    always_comb begin
        advance          = !ctrl_s[STAGES-1].valid || out_ready;
        entry_b          = in_sub ? ~in_b : in_b;
        entry_ctrl.valid = in_valid;
        entry_ctrl.carry = in_sub;
        entry_ctrl.a_msb = in_a[WIDTH-1];
        entry_ctrl.b_msb = entry_b[WIDTH-1];
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            stage_ctrl_t      ctrl_i;
            logic [WIDTH-1:0] a_i;
            logic [WIDTH-1:0] b_i;
            logic [WIDTH-1:0] sum_i;

            if (k == 0) begin : g_head
                assign ctrl_i = entry_ctrl;
                assign a_i    = in_a;
                assign b_i    = entry_b;
                assign sum_i  = '0;
            end else begin : g_body
                assign ctrl_i = ctrl_s[k-1];
                assign a_i    = a_s[k-1];
                assign b_i    = b_s[k-1];
                assign sum_i  = sum_s[k-1];
            end

            adder_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .FINAL (k == STAGES - 1)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .en       (advance),
                .ctrl_in  (ctrl_i),
                .a_in     (a_i),
                .b_in     (b_i),
                .sum_in   (sum_i),
                .ctrl_out (ctrl_s[k]),
                .a_out    (a_s[k]),
                .b_out    (b_s[k]),
                .sum_out  (sum_s[k]),
                .ovf      (ovf_s[k]),
                .zero     (zero_s[k])
            );
        end
    endgenerate

    assign in_ready  = advance;
    assign out_valid = ctrl_s[STAGES-1].valid;
    assign out_sum   = sum_s[STAGES-1];
    assign out_carry = ctrl_s[STAGES-1].carry;
    assign out_ovf   = ovf_s[STAGES-1];
    assign out_zero  = zero_s[STAGES-1];

    // Operand remnants and msb copies are fully consumed by the last stage.
    assign tail_unused = ^{a_s[STAGES-1], b_s[STAGES-1], ctrl_s[STAGES-1].a_msb,
                           ctrl_s[STAGES-1].b_msb, ovf_s, zero_s};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors and backpressure on a 32/4 instance,
// randomized streams on 8/1, 32/4 and 64/8 instances against an arithmetic reference.
module tb_pipelined_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sub;
    logic        out_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [2:0]  rdy, vld, cy, ov, zr;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic [63:0] sum64;

    int checks = 0;
    int passes = 0;

    res_t q0[$];
    res_t q1[$];
    res_t q2[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(op_a[7:0]), .in_b(op_b[7:0]), .in_sub(in_sub),
        .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum8),
        .out_carry(cy[0]), .out_ovf(ov[0]), .out_zero(zr[0])
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(op_a[31:0]), .in_b(op_b[31:0]), .in_sub(in_sub),
        .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum32),
        .out_carry(cy[1]), .out_ovf(ov[1]), .out_zero(zr[1])
    );

    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_a(op_a), .in_b(op_b), .in_sub(in_sub),
        .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum64),
        .out_carry(cy[2]), .out_ovf(ov[2]), .out_zero(zr[2])
    );

    function automatic int unsigned wid(input int k);
        return (k == 0) ? 8 : (k == 1) ? 32 : 64;
    endfunction

    // Reference: plain wide arithmetic, signed overflow judged against the W-bit signed range.
    function automatic res_t ref_model(input int unsigned w, input logic [63:0] a_raw,
                                       input logic [63:0] b_raw, input logic sub);
        res_t r;
        logic [63:0] mask, a, b;
        logic [67:0] ut;
        logic signed [67:0] sa, sb, st, smax, smin;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a = a_raw & mask;
        b = b_raw & mask;
        ut = sub ? ({4'd0, a} - {4'd0, b}) : ({4'd0, a} + {4'd0, b});
        r.sum = ut[63:0] & mask;
        r.carry = sub ? (a >= b) : ut[w];
        sa = $signed({4'd0, a});
        if (a[w-1]) sa = sa - (68'sd1 <<< w);
        sb = $signed({4'd0, b});
        if (b[w-1]) sb = sb - (68'sd1 <<< w);
        st = sub ? (sa - sb) : (sa + sb);
        smax = (68'sd1 <<< (w - 1)) - 68'sd1;
        smin = -(68'sd1 <<< (w - 1));
        r.ovf = (st > smax) || (st < smin);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic res_t obs(input int k);
        res_t r;
        case (k)
            0:       r.sum = {56'd0, sum8};
            1:       r.sum = {32'd0, sum32};
            default: r.sum = sum64;
        endcase
        r.carry = cy[k];
        r.ovf   = ov[k];
        r.zero  = zr[k];
        return r;
    endfunction

    function automatic void push_exp(input int k, input res_t r);
        case (k)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    endfunction

    function automatic res_t pop_exp(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    // Offers one beat to an empty pipeline and waits for the 32/4 result.
    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            output res_t r, output int lat);
        @(posedge clk); #1;
        op_a = {32'd0, a};
        op_b = {32'd0, b};
        in_sub = sub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!vld[1] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = obs(1);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (vld !== 3'b000) $display("FAIL reset_out_valid cyc %0d: got %b required 000", i, vld);
            else passes++;
            checks++;
            if (rdy !== 3'b111) $display("FAIL reset_in_ready cyc %0d: got %b required 111", i, rdy);
            else passes++;
            checks++;
            if ({sum32, cy[1], ov[1], zr[1]} !== 35'd0)
                $display("FAIL reset_outputs32 cyc %0d: got %h required 0", i, {sum32, cy[1], ov[1], zr[1]});
            else passes++;
            checks++;
            if ({sum64, cy[2], ov[2], zr[2]} !== 67'd0)
                $display("FAIL reset_outputs64 cyc %0d: got %h required 0", i, {sum64, cy[2], ov[2], zr[2]});
            else passes++;
        end
    endtask

    task automatic test_add();
        res_t r;
        int lat;
        send_one(32'h0000_0005, 32'h0000_0003, 1'b0, r, lat);
        checks++;
        if (lat !== 4) $display("FAIL add_latency: got %0d required 4", lat);
        else passes++;
        checks++;
        if ({r.sum[31:0], r.carry, r.ovf, r.zero} !== {32'h0000_0008, 3'b000})
            $display("FAIL add_5_3: got %h required %h", {r.sum[31:0], r.carry, r.ovf, r.zero},
                     {32'h0000_0008, 3'b000});
        else passes++;
    endtask

    task automatic test_wrap();
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        logic [34:0] te [2];
        res_t r;
        int lat;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h1; te[0] = {32'h0000_0000, 3'b101};
        ta[1] = 32'h7FFF_FFFF; tb[1] = 32'h1; te[1] = {32'h8000_0000, 3'b010};
        for (int i = 0; i < 2; i++) begin
            send_one(ta[i], tb[i], 1'b0, r, lat);
            checks++;
            if ({r.sum[31:0], r.carry, r.ovf, r.zero} !== te[i])
                $display("FAIL wrap_%0d: got %h required %h", i, {r.sum[31:0], r.carry, r.ovf, r.zero}, te[i]);
            else passes++;
        end
    endtask

    task automatic test_sub();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [34:0] te [3];
        res_t r;
        int lat;
        ta[0] = 32'h5;         tb[0] = 32'h5; te[0] = {32'h0000_0000, 3'b101};
        ta[1] = 32'h3;         tb[1] = 32'h5; te[1] = {32'hFFFF_FFFE, 3'b000};
        ta[2] = 32'h8000_0000; tb[2] = 32'h1; te[2] = {32'h7FFF_FFFF, 3'b110};
        for (int i = 0; i < 3; i++) begin
            send_one(ta[i], tb[i], 1'b1, r, lat);
            checks++;
            if ({r.sum[31:0], r.carry, r.ovf, r.zero} !== te[i])
                $display("FAIL sub_%0d: got %h required %h", i, {r.sum[31:0], r.carry, r.ovf, r.zero}, te[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [8];
        logic [31:0] bb [8];
        logic        bs [8];
        res_t expq[$];
        res_t e;
        int sent = 0, got = 0, stall_left = 0, stalls = 0, cyc = 0, extra = 0;
        logic first_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ba[i] = $urandom;
            bb[i] = $urandom;
            bs[i] = 1'($urandom_range(0, 1));
        end
        while (got < 8 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            in_valid = (sent < 8);
            if (sent < 8) begin
                op_a = {32'd0, ba[sent]};
                op_b = {32'd0, bb[sent]};
                in_sub = bs[sent];
            end
            out_ready = (stall_left == 0);
            @(negedge clk);
            if (stall_left > 0) begin
                stalls++;
                checks++;
                if (rdy[1] !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", rdy[1]);
                else passes++;
                checks++;
                if (expq.size() == 0 || {vld[1], obs(1)} !== {1'b1, expq[0]})
                    $display("FAIL bp_hold: got %h required valid beat %0d", {vld[1], obs(1)}, got);
                else passes++;
                stall_left--;
            end
            if (in_valid && rdy[1]) begin
                expq.push_back(ref_model(32, op_a, op_b, in_sub));
                sent++;
            end
            if (vld[1] && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    $display("FAIL bp_extra_result: got %h required none", obs(1));
                end else begin
                    e = expq.pop_front();
                    if (obs(1) !== e) $display("FAIL bp_result_%0d: got %h required %h", got, obs(1), e);
                    else passes++;
                end
                got++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    stall_left = 3;
                end
            end
        end
        checks++;
        if ({got, sent, stalls} !== {32'd8, 32'd8, 32'd3})
            $display("FAIL bp_counts: got %0d results %0d sent %0d stalls required 8 8 3", got, sent, stalls);
        else passes++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vld[1]) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL bp_duplicates: got %0d extra results required 0", extra);
        else passes++;
    endtask

    // One randomized cycle across all three instances, with scoreboarding.
    task automatic step_random(input logic v, input logic rdy_o, input logic do_rst, input logic after_rst);
        res_t e;
        logic [63:0] nb;
        @(posedge clk); #1;
        rst = do_rst;
        in_valid = v;
        out_ready = rdy_o;
        in_sub = 1'($urandom_range(0, 1));
        op_a = {$urandom, $urandom};
        nb = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       op_b = op_a;
            1:       op_b = ~op_a;
            2:       op_b = -op_a;
            3:       op_b = 64'd0;
            default: op_b = nb;
        endcase
        if ($urandom_range(0, 15) == 0) op_a = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        if (after_rst) begin
            checks++;
            if (vld !== 3'b000) $display("FAIL rand_flush: got out_valid %b required 000", vld);
            else passes++;
        end
        if (do_rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (in_valid && rdy[k]) push_exp(k, ref_model(wid(k), op_a, op_b, in_sub));
                if (vld[k] && out_ready) begin
                    checks++;
                    if (qsize(k) == 0) begin
                        $display("FAIL rand_w%0d_unexpected: got %h required no result", wid(k), obs(k));
                    end else begin
                        e = pop_exp(k);
                        if (obs(k) !== e) $display("FAIL rand_w%0d: got %h required %h", wid(k), obs(k), e);
                        else passes++;
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int acc = 0, cyc = 0;
        logic v, r;
        apply_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        while (acc < 10000 && cyc < 40000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            step_random(v, r, (cyc == 6000), (cyc == 6001));
            if (cyc != 6000 && in_valid && rdy[1]) acc++;
            cyc++;
        end
        checks++;
        if (acc < 10000) $display("FAIL rand_budget: got %0d beats required 10000", acc);
        else passes++;
        for (int i = 0; i < 16; i++) step_random(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (qsize(k) !== 0) $display("FAIL rand_w%0d_drain: got %0d pending required 0", wid(k), qsize(k));
            else passes++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_sub = 1'b0;
        out_ready = 1'b1;
        op_a = 64'd0;
        op_b = 64'd0;
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
